// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter and its round-robin core.
// Combinational helpers only; no state lives here.
// Upstream backpressure is handled by the modules that import this package.
package sram_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DEPTH_DEF      = 1024;
    localparam int DATA_WIDTH_DEF = 128;
    localparam int MASK_UNIT_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int MAX_REQ        = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        HOLD   = 2'd2
    } resp_state_e;

    // One-hot grant: first set bit of req searching from last+1, wrapping at n.
    // The wrap is an explicit compare so n need not be a power of two.
    function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                                   input logic [3:0]         last,
                                                   input int                 n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = {28'd0, last} + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[3:0]]) begin
                    gnt[idx[3:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin pick over NUM_REQ requests with a registered last-winner pointer.
// Zero latency: grant is combinational from req_i; pointer moves on any grant.
// Callers apply backpressure by masking req_i; a zero request vector grants nobody.
module rr_arbiter_core
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    logic [IDX_W-1:0]   last_q;
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        gnt_ext                = rr_next(req_ext, 4'(last_q), NUM_REQ);
        gnt_o                  = gnt_ext[NUM_REQ-1:0];
        gnt_vld_o              = |gnt_ext;
        gnt_idx_o              = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (gnt_ext[i]) gnt_idx_o = IDX_W'(i);
        end
    end

    // Reset to the highest index so requester 0 is first in line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (gnt_vld_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM rw port among NUM_REQ requesters round-robin; SRAM_ARB_WRITE_ACK_EN adds write acks.
// Access issues in the grant cycle; read data returns one cycle later and is held until accepted.
// A pending response whose owner is not ready blocks all new grants until it is taken.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MASK_UNIT  = MASK_UNIT_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MASK_WIDTH = (DATA_WIDTH + MASK_UNIT - 1) / MASK_UNIT
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*MASK_WIDTH-1:0] req_mask_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          sram_enable_o,
    output logic                          sram_write_o,
    output logic [ADDR_WIDTH-1:0]         sram_addr_o,
    output logic [MASK_WIDTH-1:0]         sram_mask_o,
    output logic [DATA_WIDTH-1:0]         sram_dataIn_o,
    input  logic [DATA_WIDTH-1:0]         sram_dataOut_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("sram_port_arbiter: NUM_REQ out of range");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_port_arbiter: DEPTH does not fit in ADDR_WIDTH");
    end

    resp_state_e           state_q;
    logic [IDX_W-1:0]      owner_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [NUM_REQ-1:0]    resp_vld_q;

    logic                  pending;
    logic                  owner_rdy;
    logic                  stall;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic                  sel_write;
    logic                  resp_fire;
    logic [DATA_WIDTH-1:0] issued_data;

    assign pending   = (state_q != IDLE);
    assign owner_rdy = resp_ready_i[owner_q];
    assign stall     = pending && !owner_rdy;
    // Reset gates requests combinationally so the SRAM enable drops with reset.
    assign arb_req   = (stall || !reset_n_i) ? '0 : req_valid_i;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i     (clock_i),
        .rst_n_i   (reset_n_i),
        .req_i     (arb_req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready_o   = gnt;
    assign sel_write     = req_write_i[gnt_idx];
    assign sram_enable_o = gnt_vld;
    assign sram_write_o  = sel_write;
    assign sram_addr_o   = req_addr_i[int'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sram_mask_o   = req_mask_i[int'(gnt_idx) * MASK_WIDTH +: MASK_WIDTH];
    assign sram_dataIn_o = req_data_i[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

`ifdef SRAM_ARB_WRITE_ACK_EN
    logic wr_ack_q;
    assign resp_fire   = gnt_vld;
    assign issued_data = wr_ack_q ? '0 : sram_dataOut_i;
`else
    assign resp_fire   = gnt_vld && !sel_write;
    assign issued_data = sram_dataOut_i;
`endif

    assign resp_valid_o = resp_vld_q;
    assign resp_data_o  = (state_q == HOLD) ? hold_q : issued_data;

    // Response tracker: an accepted (or absent) response frees the slot for this cycle's grant.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            hold_q     <= '0;
            resp_vld_q <= '0;
`ifdef SRAM_ARB_WRITE_ACK_EN
            wr_ack_q   <= 1'b0;
`endif
        end else if (!stall) begin
            if (resp_fire) begin
                state_q    <= ISSUED;
                owner_q    <= gnt_idx;
                resp_vld_q <= gnt;
`ifdef SRAM_ARB_WRITE_ACK_EN
                wr_ack_q   <= sel_write;
`endif
            end else begin
                state_q    <= IDLE;
                resp_vld_q <= '0;
            end
        end else if (state_q == ISSUED) begin
            state_q <= HOLD;
            hold_q  <= issued_data;
        end
    end

endmodule
